// File: rtl/otter_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives the 1-cycle synchronous instruction port and
// buffers returned words in a prefetch FIFO presented to decode through a valid/ready handshake.
module otter_fetch_unit #(
  parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        imem_err,
  output logic        de_valid,
  input  logic        de_ready,
  output logic [31:0] de_ir,
  output logic [31:0] de_pc,
  output logic [31:0] de_next_pc,
  output logic        de_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthCnt = (CntW + 1)'(FIFO_DEPTH);

  logic [31:0]     fpc_q, fpc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     inflight_pc_q, inflight_pc_d;

  logic [31:0] ir_mem  [FIFO_DEPTH];
  logic [31:0] pc_mem  [FIFO_DEPTH];
  logic        err_mem [FIFO_DEPTH];

  logic [CntW:0] occupancy;
  logic          issue;
  logic          push;
  logic          pop;

  // Credit check counts the in-flight word so a response never lands in a full FIFO.
  assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
  assign issue     = !rst && !redirect && (occupancy < DepthCnt);
  assign push      = inflight_q && !redirect && !rst;
  assign pop       = de_valid && de_ready && !redirect && !rst;

  always_comb begin
    fpc_d         = fpc_q;
    count_d       = count_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      fpc_d   = redirect_pc;
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (issue) begin
        fpc_d         = fpc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = fpc_q;
      end
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q         <= RESET_VEC;
      count_q       <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fpc_q         <= fpc_d;
      count_q       <= count_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ir_mem[wptr_q]  <= imem_dout;
      pc_mem[wptr_q]  <= inflight_pc_q;
      err_mem[wptr_q] <= imem_err || (inflight_pc_q[1:0] != 2'b00);
    end
  end

  always_comb begin
    imem_rd    = issue;
    imem_addr  = fpc_q;
    de_valid   = (count_q != '0);
    de_ir      = '0;
    de_pc      = '0;
    de_next_pc = '0;
    de_err     = 1'b0;
    if (de_valid) begin
      de_ir      = ir_mem[rptr_q];
      de_pc      = pc_mem[rptr_q];
      de_next_pc = pc_mem[rptr_q] + 32'd4;
      de_err     = err_mem[rptr_q];
    end
  end

endmodule
